// File: rtl/reg_write_arbiter_if.sv
// Writeback bus between the two requesters (ALU path A, load path M) and the
// register-file write arbiter.
//   hold                   : freeze, no new grants while high
//   req_x / dest_x / data_x: writeback request, held stable until ack_x
//   ack_a / ack_m          : one-cycle grant pulses
//   wr_en/wr_addr/wr_data  : register-file write port
//   reg_dst_sel            : destination-mux select (0 = A path, 1 = M path)
//   stall                  : a request is waiting and not granted this cycle
interface reg_write_arbiter_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2
);
  logic              hold;
  logic              req_a;
  logic [ADDR_W-1:0] dest_a;
  logic [DATA_W-1:0] data_a;
  logic              req_m;
  logic [ADDR_W-1:0] dest_m;
  logic [DATA_W-1:0] data_m;
  logic              ack_a;
  logic              ack_m;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              reg_dst_sel;
  logic              stall;

  // Requester / environment side.
  modport master (
    output hold, req_a, dest_a, data_a, req_m, dest_m, data_m,
    input  ack_a, ack_m, wr_en, wr_addr, wr_data, reg_dst_sel, stall
  );

  // Arbiter side.
  modport slave (
    input  hold, req_a, dest_a, data_a, req_m, dest_m, data_m,
    output ack_a, ack_m, wr_en, wr_addr, wr_data, reg_dst_sel, stall
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Shares the single register-file write port between the ALU writeback path (A)
// and the memory-load writeback path (M). The winning request is registered and
// shows up one cycle later as wr_en + ack. Round-robin between A and M, except
// that a same-register conflict always lets the load (older instruction) write
// first so the ALU value lands last.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : reg_write_arbiter_if.slave (requests in, write port/acks/stall out)
module reg_write_arbiter #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2
) (
  input logic              clock,
  input logic              reset,
  reg_write_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic LastA = 1'b0;
  localparam logic LastM = 1'b1;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_m_q, ack_m_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              sel_q, sel_d;
  logic              stall_q, stall_d;

  logic elig_a, elig_m;
  logic grant_a, grant_m;

  // A request whose ack is showing this cycle still has req high; it must not
  // be granted a second time.
  assign elig_a = bus.req_a & ~ack_a_q;
  assign elig_m = bus.req_m & ~ack_m_q;

  always_comb begin
    state_d      = StIdle;
    last_grant_d = last_grant_q;
    ack_a_d      = 1'b0;
    ack_m_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    sel_d        = sel_q;
    stall_d      = 1'b0;
    grant_a      = 1'b0;
    grant_m      = 1'b0;

    if (bus.hold) begin
      stall_d = elig_a | elig_m;
    end else if (elig_a && elig_m) begin
      if (bus.dest_a == bus.dest_m) begin
        // Ordering override: load first, fairness pointer untouched.
        grant_m = 1'b1;
      end else if (last_grant_q == LastM) begin
        grant_a      = 1'b1;
        last_grant_d = LastA;
      end else begin
        grant_m      = 1'b1;
        last_grant_d = LastM;
      end
    end else if (elig_a) begin
      grant_a = 1'b1;
    end else if (elig_m) begin
      grant_m = 1'b1;
    end

    if (grant_a) begin
      state_d   = StGrant;
      ack_a_d   = 1'b1;
      wr_addr_d = bus.dest_a;
      wr_data_d = bus.data_a;
      sel_d     = 1'b0;
      stall_d   = elig_m;
    end else if (grant_m) begin
      state_d   = StGrant;
      ack_m_d   = 1'b1;
      wr_addr_d = bus.dest_m;
      wr_data_d = bus.data_m;
      sel_d     = 1'b1;
      stall_d   = elig_a;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= LastM;
      ack_a_q      <= 1'b0;
      ack_m_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      sel_q        <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ack_a_q      <= ack_a_d;
      ack_m_q      <= ack_m_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      sel_q        <= sel_d;
      stall_q      <= stall_d;
    end
  end

  assign bus.wr_en       = (state_q == StGrant);
  assign bus.ack_a       = ack_a_q;
  assign bus.ack_m       = ack_m_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.reg_dst_sel = sel_q;
  assign bus.stall       = stall_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  logic [3:0] regfile [4];

  reg_write_arbiter_if #(.DATA_W(4), .ADDR_W(2)) bus ();

  reg_write_arbiter #(.DATA_W(4), .ADDR_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file the write port feeds.
  always @(posedge clock) begin
    if (bus.wr_en) regfile[bus.wr_addr] <= bus.wr_data;
  end

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.hold   = 1'b0;
    bus.req_a  = 1'b0;
    bus.dest_a = 2'd0;
    bus.data_a = 4'd0;
    bus.req_m  = 1'b0;
    bus.dest_m = 2'd0;
    bus.data_m = 4'd0;
  endtask

  task automatic clean_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.req_a = 1'b1; bus.dest_a = 2'd1; bus.data_a = 4'h3;
    bus.req_m = 1'b1; bus.dest_m = 2'd3; bus.data_m = 4'h7;
    step();
    step();
    checks++;
    if ({bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall}
        !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ack_a=%b ack_m=%b wr_en=%b addr=%0d data=%h sel=%b stall=%b want all 0",
               bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall}
        !== {1'b1, 1'b0, 1'b1, 2'd1, 4'h3, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_first_grant: got ack_a=%b ack_m=%b wr_en=%b addr=%0d data=%h sel=%b stall=%b want 1 0 1 1 3 0 1",
               bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall);
    end
    bus.req_a = 1'b0;
    step();
    checks++;
    if ({bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall}
        !== {1'b0, 1'b1, 1'b1, 2'd3, 4'h7, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_loser_grant: got ack_a=%b ack_m=%b wr_en=%b addr=%0d data=%h sel=%b stall=%b want 0 1 1 3 7 1 0",
               bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall);
    end
    bus.req_m = 1'b0;
    step();
    checks++;
    if (bus.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_drain: got wr_en=%b want 0", bus.wr_en);
    end
  endtask

  task automatic test_single_a();
    bus.req_a = 1'b1; bus.dest_a = 2'd2; bus.data_a = 4'hB;
    step();
    checks++;
    if ({bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall}
        !== {1'b1, 1'b0, 1'b1, 2'd2, 4'hB, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL single_a_grant: got ack_a=%b ack_m=%b wr_en=%b addr=%0d data=%h sel=%b stall=%b want 1 0 1 2 b 0 0",
               bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall);
    end
    bus.req_a = 1'b0;
    step();
    checks++;
    if ({bus.wr_en, bus.ack_a} !== 2'b00) begin
      failures++;
      $display("FAIL single_a_release: got wr_en=%b ack_a=%b want 0 0", bus.wr_en, bus.ack_a);
    end
  endtask

  task automatic test_round_robin();
    logic exp_m;
    clean_reset();
    bus.req_a = 1'b1; bus.dest_a = 2'd1; bus.data_a = 4'h1;
    bus.req_m = 1'b1; bus.dest_m = 2'd3; bus.data_m = 4'hE;
    exp_m = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({bus.wr_en, bus.ack_a, bus.ack_m, bus.reg_dst_sel, bus.wr_addr}
          !== {1'b1, ~exp_m, exp_m, exp_m, (exp_m ? 2'd3 : 2'd1)}) begin
        failures++;
        $display("FAIL round_robin_%0d: got wr_en=%b ack_a=%b ack_m=%b sel=%b addr=%0d want M=%b",
                 i, bus.wr_en, bus.ack_a, bus.ack_m, bus.reg_dst_sel, bus.wr_addr, exp_m);
      end
      if (i == 0) begin
        checks++;
        if (bus.stall !== 1'b1) begin
          failures++;
          $display("FAIL round_robin_stall: got stall=%b want 1", bus.stall);
        end
      end
      exp_m = ~exp_m;
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_same_reg_conflict();
    bus.req_a = 1'b1; bus.dest_a = 2'd2; bus.data_a = 4'h5;
    bus.req_m = 1'b1; bus.dest_m = 2'd2; bus.data_m = 4'h9;
    step();
    checks++;
    if ({bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall}
        !== {1'b0, 1'b1, 1'b1, 2'd2, 4'h9, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL conflict_load_first: got ack_a=%b ack_m=%b wr_en=%b addr=%0d data=%h sel=%b stall=%b want 0 1 1 2 9 1 1",
               bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall);
    end
    bus.req_m = 1'b0;
    step();
    checks++;
    if ({bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall}
        !== {1'b1, 1'b0, 1'b1, 2'd2, 4'h5, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL conflict_alu_last: got ack_a=%b ack_m=%b wr_en=%b addr=%0d data=%h sel=%b stall=%b want 1 0 1 2 5 0 0",
               bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall);
    end
    bus.req_a = 1'b0;
    step();
    checks++;
    if (regfile[2] !== 4'h5) begin
      failures++;
      $display("FAIL conflict_final_reg: got reg2=%h want 5", regfile[2]);
    end
  endtask

  task automatic test_hold();
    bus.hold  = 1'b1;
    bus.req_m = 1'b1; bus.dest_m = 2'd1; bus.data_m = 4'h4;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.wr_en, bus.ack_m, bus.ack_a, bus.stall} !== 4'b0001) begin
        failures++;
        $display("FAIL hold_%0d: got wr_en=%b ack_m=%b ack_a=%b stall=%b want 0 0 0 1",
                 i, bus.wr_en, bus.ack_m, bus.ack_a, bus.stall);
      end
    end
    bus.hold = 1'b0;
    step();
    checks++;
    if ({bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall}
        !== {1'b1, 1'b1, 2'd1, 4'h4, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL hold_release: got ack_m=%b wr_en=%b addr=%0d data=%h sel=%b stall=%b want 1 1 1 4 1 0",
               bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall);
    end
    bus.req_m = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_grant();
    clean_reset();
    bus.req_a = 1'b1; bus.dest_a = 2'd0; bus.data_a = 4'h1;
    step();
    checks++;
    if (bus.ack_a !== 1'b1) begin
      failures++;
      $display("FAIL midreset_setup: got ack_a=%b want 1", bus.ack_a);
    end
    bus.req_a = 1'b0;
    bus.req_m = 1'b1; bus.dest_m = 2'd3; bus.data_m = 4'h6;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall}
          !== 12'd0) begin
        failures++;
        $display("FAIL midreset_%0d: got ack_a=%b ack_m=%b wr_en=%b addr=%0d data=%h sel=%b stall=%b want all 0",
                 i, bus.ack_a, bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel, bus.stall);
      end
    end
    reset = 1'b0;
    step();
    checks++;
    if ({bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel}
        !== {1'b1, 1'b1, 2'd3, 4'h6, 1'b1}) begin
      failures++;
      $display("FAIL midreset_regrant: got ack_m=%b wr_en=%b addr=%0d data=%h sel=%b want 1 1 3 6 1",
               bus.ack_m, bus.wr_en, bus.wr_addr, bus.wr_data, bus.reg_dst_sel);
    end
    bus.req_m = 1'b0;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) regfile[i] = 4'h0;
    test_reset();
    test_single_a();
    test_round_robin();
    test_same_reg_conflict();
    test_hold();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
